log_ops_exerciser: RTL and testbench

- Self-checking initiator for the 4-input-group logical-operator unit.
- Sweeps every combination of operands a, b and c, and drives them to the unit under test.
- Samples the unit's five result flags (u, v, x, y, z) and compares them against an internal golden model.
- Reports mismatch count, first failing vector and pass/done status. Used on the bring-up board and in regression benches.

---
 rtl/log_ops_exerciser.sv | 155 +++++++++++++++
 tb/tb_log_ops_exerciser.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/log_ops_exerciser.sv
// Self-checking sweep initiator for the a/b/c logical-operator unit: drives every
// {a,b,c} vector, samples the five result flags LAT cycles later and scores them.
module log_ops_exerciser #(
    parameter int W   = 4,
    parameter int LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [W-1:0]      a_o,
    output logic [W-1:0]      b_o,
    output logic [W-1:0]      c_o,
    input  logic              u_i,
    input  logic              v_i,
    input  logic              x_i,
    input  logic              y_i,
    input  logic              z_i,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [3*W:0]      err_cnt,
    output logic              fail_seen,
    output logic [3*W-1:0]    first_vec,
    output logic [4:0]        first_obs
);

    localparam int VW  = 3 * W;
    localparam int WCW = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [WCW-1:0] WC_LAST = WCW'(LAT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Reference flags {u,v,x,y,z}; each operand only matters through "is nonzero".
    function automatic logic [4:0] golden_flags(input logic [VW-1:0] vec);
        logic op_a;
        logic op_b;
        logic op_c;
        op_a = |vec[VW-1:2*W];
        op_b = |vec[2*W-1:W];
        op_c = |vec[W-1:0];
        return {(!op_b || op_c), (op_a && !op_c), (op_a || op_b), (op_a && op_c), !op_b};
    endfunction

    state_t              r_state;
    logic [VW-1:0]       r_vec;
    logic [WCW-1:0]      r_wc;
    logic [VW:0]         r_err_cnt;
    logic                r_fail_seen;
    logic [VW-1:0]       r_first_vec;
    logic [4:0]          r_first_obs;
    logic                r_busy;
    logic                r_done;
    logic                r_pass;

    logic [4:0]          w_obs;
    logic [4:0]          w_exp;
    logic                w_mismatch;
    logic                w_last;
    logic                w_sample;

    assign w_obs      = {u_i, v_i, x_i, y_i, z_i};
    assign w_exp      = golden_flags(r_vec);
    assign w_mismatch = (w_obs != w_exp);
    assign w_last     = (r_vec == {VW{1'b1}});
    assign w_sample   = (r_wc == WC_LAT_LAST());

    function automatic logic [WCW-1:0] WC_LAT_LAST();
        return WC_LAST;
    endfunction

    // Sweep sequencer, scoreboard and all registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_vec       <= {VW{1'b0}};
            r_wc        <= {WCW{1'b0}};
            r_err_cnt   <= {(VW+1){1'b0}};
            r_fail_seen <= 1'b0;
            r_first_vec <= {VW{1'b0}};
            r_first_obs <= 5'b00000;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_state     <= ST_RUN;
                        r_vec       <= {VW{1'b0}};
                        r_wc        <= {WCW{1'b0}};
                        r_err_cnt   <= {(VW+1){1'b0}};
                        r_fail_seen <= 1'b0;
                        r_first_vec <= {VW{1'b0}};
                        r_first_obs <= 5'b00000;
                        r_busy      <= 1'b1;
                        r_done      <= 1'b0;
                        r_pass      <= 1'b0;
                    end else begin
                        r_state <= r_state;
                    end
                end
                ST_RUN: begin
                    if (w_sample) begin
                        if (w_mismatch) begin
                            r_err_cnt <= r_err_cnt + {{VW{1'b0}}, 1'b1};
                            if (!r_fail_seen) begin
                                r_first_vec <= r_vec;
                                r_first_obs <= w_obs;
                                r_fail_seen <= 1'b1;
                            end else begin
                                r_fail_seen <= 1'b1;
                            end
                        end else begin
                            r_err_cnt <= r_err_cnt;
                        end
                        // Last vector is scored on this same edge before DONE is entered.
                        if (w_last) begin
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_pass  <= (r_err_cnt == {(VW+1){1'b0}}) && !w_mismatch;
                        end else begin
                            r_vec <= r_vec + {{(VW-1){1'b0}}, 1'b1};
                            r_wc  <= {WCW{1'b0}};
                        end
                    end else begin
                        r_wc <= r_wc + {{(WCW-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_pass  <= 1'b0;
                end
            endcase
        end
    end

    assign a_o       = r_vec[VW-1:2*W];
    assign b_o       = r_vec[2*W-1:W];
    assign c_o       = r_vec[W-1:0];
    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign err_cnt   = r_err_cnt;
    assign fail_seen = r_fail_seen;
    assign first_vec = r_first_vec;
    assign first_obs = r_first_obs;

endmodule

// File: tb/tb_log_ops_exerciser.sv
// Directed bench for log_ops_exerciser: one LAT=1 instance on a combinational unit
// model and one LAT=3 instance on a two-register-stage unit model, with fault modes.
module tb_log_ops_exerciser;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start1;
    logic        start3;
    int          mode;
    int          vectors;
    int          miscompares;

    logic [3:0]  a1, b1, c1, a3, b3, c3;
    logic [4:0]  f1, f3, p1, p2;
    logic        busy1, done1, pass1, fs1, busy3, done3, pass3, fs3;
    logic [12:0] err1, err3;
    logic [11:0] fv1, fv3;
    logic [4:0]  fo1, fo3;

    // Behavioural operator unit with optional faults: 1 = x stuck at 0, 2 = z inverted.
    function automatic logic [4:0] unit_model(input logic [3:0] a, input logic [3:0] b,
                                              input logic [3:0] c, input int m);
        logic ka, kb, kc;
        logic [4:0] f;
        ka = |a; kb = |b; kc = |c;
        f  = {(!kb || kc), (ka && !kc), (ka || kb), (ka && kc), !kb};
        if (m == 1) f[2] = 1'b0;
        else if (m == 2) f[0] = ~f[0];
        return f;
    endfunction

    assign f1 = unit_model(a1, b1, c1, mode);

    always_ff @(posedge clk) begin
        p1 <= unit_model(a3, b3, c3, mode);
        p2 <= p1;
    end
    assign f3 = p2;

    log_ops_exerciser #(.W(4), .LAT(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1),
        .a_o(a1), .b_o(b1), .c_o(c1),
        .u_i(f1[4]), .v_i(f1[3]), .x_i(f1[2]), .y_i(f1[1]), .z_i(f1[0]),
        .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1),
        .fail_seen(fs1), .first_vec(fv1), .first_obs(fo1)
    );

    log_ops_exerciser #(.W(4), .LAT(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3),
        .a_o(a3), .b_o(b3), .c_o(c3),
        .u_i(f3[4]), .v_i(f3[3]), .x_i(f3[2]), .y_i(f3[1]), .z_i(f3[0]),
        .busy(busy3), .done(done3), .pass(pass3), .err_cnt(err3),
        .fail_seen(fs3), .first_vec(fv3), .first_obs(fo3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulses start1 for one edge, then counts edges until done1 (bounded).
    task automatic sweep1(output int n, input int limit);
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        n = 0;
        while (!done1 && n < limit) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        vectors++;
        if ({a1, b1, c1, busy1, done1, pass1, err1, fs1, fv1, fo1} !== 48'd0) begin
            miscompares++;
            $display("FAIL reset_lat1: got %h expected 0", {a1, b1, c1, busy1, done1, pass1, err1, fs1, fv1, fo1});
        end
        vectors++;
        if ({a3, b3, c3, busy3, done3, pass3, err3, fs3, fv3, fo3} !== 48'd0) begin
            miscompares++;
            $display("FAIL reset_lat3: got %h expected 0", {a3, b3, c3, busy3, done3, pass3, err3, fs3, fv3, fo3});
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_ideal();
        int n;
        mode = 0;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        vectors++;
        if (busy1 !== 1'b1) begin
            miscompares++;
            $display("FAIL ideal_busy: got %b expected 1", busy1);
        end
        n = 0;
        while (!done1 && n < 5000) begin
            tick();
            n++;
        end
        vectors++;
        if (n !== 4096) begin
            miscompares++;
            $display("FAIL ideal_length: got %0d expected 4096", n);
        end
        vectors++;
        if ({err1, pass1, fs1, busy1} !== {13'd0, 1'b1, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL ideal_status: got err=%0d pass=%b fail_seen=%b busy=%b expected 0/1/0/0", err1, pass1, fs1, busy1);
        end
        vectors++;
        if ({a1, b1, c1} !== 12'hFFF) begin
            miscompares++;
            $display("FAIL ideal_operands: got %h expected fff", {a1, b1, c1});
        end
        tick();
        tick();
        vectors++;
        if ({done1, pass1, a1, b1, c1} !== {1'b1, 1'b1, 12'hFFF}) begin
            miscompares++;
            $display("FAIL ideal_hold: got done=%b pass=%b ops=%h expected 1/1/fff", done1, pass1, {a1, b1, c1});
        end
    endtask

    task automatic test_x_stuck();
        int n;
        mode = 1;
        sweep1(n, 5000);
        vectors++;
        if (n !== 4096) begin
            miscompares++;
            $display("FAIL xstuck_length: got %0d expected 4096", n);
        end
        vectors++;
        if (err1 !== 13'd4080) begin
            miscompares++;
            $display("FAIL xstuck_err_cnt: got %0d expected 4080", err1);
        end
        vectors++;
        if ({fs1, fv1, fo1, pass1} !== {1'b1, 12'h010, 5'b00000, 1'b0}) begin
            miscompares++;
            $display("FAIL xstuck_first: got fs=%b vec=%h obs=%b pass=%b expected 1/010/00000/0", fs1, fv1, fo1, pass1);
        end
    endtask

    task automatic test_z_invert();
        int n;
        mode = 2;
        sweep1(n, 5000);
        vectors++;
        if (err1 !== 13'd4096) begin
            miscompares++;
            $display("FAIL zinv_err_cnt: got %0d expected 4096", err1);
        end
        vectors++;
        if ({fs1, fv1, fo1, pass1} !== {1'b1, 12'h000, 5'b10000, 1'b0}) begin
            miscompares++;
            $display("FAIL zinv_first: got fs=%b vec=%h obs=%b pass=%b expected 1/000/10000/0", fs1, fv1, fo1, pass1);
        end
    endtask

    task automatic test_reset_mid_sweep();
        int n;
        mode = 1;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int i = 0; i < 1000; i++) tick();
        vectors++;
        if ({err1, busy1} !== {13'd984, 1'b1}) begin
            miscompares++;
            $display("FAIL midsweep_progress: got err=%0d busy=%b expected 984/1", err1, busy1);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vectors++;
        if ({a1, b1, c1, busy1, done1, pass1, err1, fs1, fv1, fo1} !== 48'd0) begin
            miscompares++;
            $display("FAIL midsweep_reset: got %h expected 0", {a1, b1, c1, busy1, done1, pass1, err1, fs1, fv1, fo1});
        end
        tick();
        tick();
        vectors++;
        if ({busy1, a1, b1, c1} !== 13'd0) begin
            miscompares++;
            $display("FAIL midsweep_idle: got busy=%b ops=%h expected 0/000", busy1, {a1, b1, c1});
        end
        mode = 0;
        sweep1(n, 5000);
        vectors++;
        if ({n, err1, pass1, fs1} !== {32'd4096, 13'd0, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL midsweep_clean: got len=%0d err=%0d pass=%b fs=%b expected 4096/0/1/0", n, err1, pass1, fs1);
        end
    endtask

    task automatic test_start_ignored_and_restart();
        int n;
        mode = 1;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        n = 0;
        while (!done1 && n < 5000) begin
            start1 = (n == 10 || n == 2000) ? 1'b1 : 1'b0;
            tick();
            n++;
        end
        start1 = 1'b0;
        vectors++;
        if ({n, err1} !== {32'd4096, 13'd4080}) begin
            miscompares++;
            $display("FAIL ignored_start: got len=%0d err=%0d expected 4096/4080", n, err1);
        end
        mode = 0;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        vectors++;
        if ({done1, busy1, err1, fs1, fv1, a1, b1, c1} !== {1'b0, 1'b1, 13'd0, 1'b0, 12'h000, 12'h000}) begin
            miscompares++;
            $display("FAIL restart_clear: got done=%b busy=%b err=%0d fs=%b fv=%h ops=%h expected 0/1/0/0/000/000",
                     done1, busy1, err1, fs1, fv1, {a1, b1, c1});
        end
        n = 0;
        while (!done1 && n < 5000) begin
            tick();
            n++;
        end
        vectors++;
        if ({n, err1, pass1} !== {32'd4096, 13'd0, 1'b1}) begin
            miscompares++;
            $display("FAIL restart_sweep: got len=%0d err=%0d pass=%b expected 4096/0/1", n, err1, pass1);
        end
    endtask

    task automatic test_lat3();
        int n;
        mode = 0;
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        n = 0;
        while (!done3 && n < 13000) begin
            tick();
            n++;
        end
        vectors++;
        if (n !== 12288) begin
            miscompares++;
            $display("FAIL lat3_length: got %0d expected 12288", n);
        end
        vectors++;
        if ({err3, pass3, fs3, a3, b3, c3} !== {13'd0, 1'b1, 1'b0, 12'hFFF}) begin
            miscompares++;
            $display("FAIL lat3_status: got err=%0d pass=%b fs=%b ops=%h expected 0/1/0/fff", err3, pass3, fs3, {a3, b3, c3});
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        mode        = 0;
        rst         = 1'b1;
        start1      = 1'b0;
        start3      = 1'b0;
        test_reset();
        test_ideal();
        test_x_stuck();
        test_z_invert();
        test_reset_mid_sweep();
        test_start_ignored_and_restart();
        test_lat3();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
